// File: rtl/superfrog_pkg.sv
// Shared game types and small helpers for the obstacle field.
// Holds the game-state encoding, the default coordinate width and two pure functions.
package superfrog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int CORDW_DEF = 16;

  // Lowest set bit index of v; 0 when v is all zeros.
  function automatic int prio_enc(input logic [15:0] v);
    int idx;
    idx = 0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int sat_add(input int a, input int b, input int max_v);
    return (a + b > max_v) ? max_v : a + b;
  endfunction

endpackage

// File: rtl/obstacle_lane.sv
// One falling obstacle: holds its x/y, applies per-frame motion and respawns
// above the field once it drops past the floor.
module obstacle_lane #(
  parameter int IDX       = 0,
  parameter int CORDW     = 16,
  parameter int RNDW      = 8,
  parameter int X_MIN     = 158,
  parameter int X_STEP    = 64,
  parameter int Y_INIT    = -300,
  parameter int Y_STAG    = 50,
  parameter int Y_FLOOR   = 230,
  parameter int Y_RESPAWN = -300
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             init,
  input  logic             step,
  input  logic [CORDW-1:0] speed,
  input  logic [RNDW-1:0]  rnd,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic             respawn
);

  localparam logic signed [CORDW-1:0] X_INIT_C  = CORDW'(X_MIN + IDX * X_STEP);
  localparam logic signed [CORDW-1:0] Y_INIT_C  = CORDW'(Y_INIT - IDX * Y_STAG);
  localparam logic signed [CORDW-1:0] X_MIN_C   = CORDW'(X_MIN);
  localparam logic signed [CORDW-1:0] FLOOR_C   = CORDW'(Y_FLOOR);
  localparam logic signed [CORDW-1:0] RESPAWN_C = CORDW'(Y_RESPAWN);
  localparam logic [RNDW-1:0]         RND_OFS   = RNDW'(IDX * X_STEP);

  logic signed [CORDW-1:0] x_q, x_d, y_q, y_d;
  logic [RNDW-1:0]         rnd_ofs;

  // NOTE: every signal written here gets a default first, otherwise paths
  // that skip an assignment infer latches.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    respawn = 1'b0;
    rnd_ofs = rnd + RND_OFS;   // wraps mod 2^RNDW by width
    if (init) begin
      x_d = X_INIT_C;
      y_d = Y_INIT_C;
    end else if (step) begin
      if (y_q > FLOOR_C) begin
        respawn = 1'b1;
        y_d     = RESPAWN_C;
        x_d     = X_MIN_C + CORDW'(rnd_ofs);
      end else begin
        y_d = y_q + speed;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= X_INIT_C;
      y_q <= Y_INIT_C;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/obstacle_field.sv
// Owner of N falling obstacles: game FSM, score/level, player collision and
// the opaque-pixel priority encoder; per-object motion lives in obstacle_lane.
module obstacle_field import superfrog_pkg::*; #(
  parameter int N_OBJ     = 5,
  parameter int CORDW     = CORDW_DEF,
  parameter int RNDW      = 8,
  parameter int X_MIN     = 158,
  parameter int X_STEP    = 64,
  parameter int Y_INIT    = -300,
  parameter int Y_STAG    = 50,
  parameter int Y_FLOOR   = 230,
  parameter int Y_RESPAWN = -300,
  parameter int SPEED0    = 1,
  parameter int SPEED_MAX = 6,
  parameter int SCOREW    = 8,
  parameter int LVL_SHIFT = 4,
  localparam int SELW     = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                   clk_pix,
  input  logic                   rst_n,
  input  logic                   frame,
  input  logic                   start,
  input  logic [RNDW-1:0]        rnd,
  input  logic [N_OBJ-1:0]       obj_draw,
  input  logic                   plr_draw,
  output logic [N_OBJ*CORDW-1:0] obj_x,
  output logic [N_OBJ*CORDW-1:0] obj_y,
  output logic                   obj_any,
  output logic [SELW-1:0]        obj_sel,
  output logic [1:0]             state,
  output logic                   dead,
  output logic [SCOREW-1:0]      score,
  output logic [3:0]             level,
  output logic [SELW-1:0]        hit_idx
);

  localparam int SCORE_MAX = (1 << SCOREW) - 1;

  game_state_t       state_q, state_d;
  logic [SCOREW-1:0] score_q, score_d;
  logic [SELW-1:0]   hit_q, hit_d;
  logic              lane_init, lane_step;
  logic [N_OBJ-1:0]  respawn;
  logic [CORDW-1:0]  speed;
  logic [3:0]        level_w;
  logic [31:0]       lvl_raw;
  int                spd_i;
  int                resp_cnt;

  for (genvar i = 0; i < N_OBJ; i++) begin : g_lane
    obstacle_lane #(
      .IDX(i), .CORDW(CORDW), .RNDW(RNDW), .X_MIN(X_MIN), .X_STEP(X_STEP),
      .Y_INIT(Y_INIT), .Y_STAG(Y_STAG), .Y_FLOOR(Y_FLOOR), .Y_RESPAWN(Y_RESPAWN)
    ) u_lane (
      .clk_pix (clk_pix),
      .rst_n   (rst_n),
      .init    (lane_init),
      .step    (lane_step),
      .speed   (speed),
      .rnd     (rnd),
      .x       (obj_x[i*CORDW +: CORDW]),
      .y       (obj_y[i*CORDW +: CORDW]),
      .respawn (respawn[i])
    );
  end

  always_comb begin
    lvl_raw  = 32'(score_q) >> LVL_SHIFT;
    level_w  = (lvl_raw > 32'd15) ? 4'd15 : lvl_raw[3:0];
    spd_i    = SPEED0 + int'(level_w);
    speed    = CORDW'((spd_i > SPEED_MAX) ? SPEED_MAX : spd_i);
    resp_cnt = 0;
    for (int i = 0; i < N_OBJ; i++) begin
      resp_cnt = resp_cnt + (respawn[i] ? 1 : 0);
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    hit_d     = hit_q;
    lane_init = 1'b0;
    lane_step = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PLAY;
      PLAY: begin
        // A collision on a frame cycle still lets that frame's motion land.
        lane_step = frame;
        if (frame) score_d = SCOREW'(sat_add(int'(score_q), resp_cnt, SCORE_MAX));
        if (plr_draw && |obj_draw) begin
          state_d = DEAD;
          hit_d   = SELW'(prio_enc(16'(obj_draw)));
        end
      end
      DEAD: if (start) begin
        state_d   = IDLE;
        lane_init = 1'b1;
        score_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      score_q <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hit_q   <= hit_d;
    end
  end

  assign obj_any = |obj_draw;
  assign obj_sel = SELW'(prio_enc(16'(obj_draw)));
  assign state   = state_q;
  assign dead    = (state_q == DEAD);
  assign score   = score_q;
  assign level   = level_w;
  assign hit_idx = hit_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field: default 5-object field plus a 2-object
// field tuned so both objects respawn every other frame (score saturation).
module tb_obstacle_field;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  logic [7:0] rnd = 8'h10;

  // Instance A: default parameters.
  logic        frame_a = 1'b0, start_a = 1'b0, plr_draw_a = 1'b0;
  logic [4:0]  obj_draw_a = '0;
  logic [79:0] obj_x_a, obj_y_a;
  logic        obj_any_a, dead_a;
  logic [2:0]  obj_sel_a, hit_idx_a;
  logic [1:0]  state_a;
  logic [7:0]  score_a;
  logic [3:0]  level_a;

  // Instance B: two objects sitting on the floor, respawning in place.
  logic        frame_b = 1'b0, start_b = 1'b0;
  logic [1:0]  obj_draw_b = '0;
  logic        plr_draw_b = 1'b0;
  logic [31:0] obj_x_b, obj_y_b;
  logic        obj_any_b, dead_b;
  logic [0:0]  obj_sel_b, hit_idx_b;
  logic [1:0]  state_b;
  logic [7:0]  score_b;
  logic [3:0]  level_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_pix = ~clk_pix;

  obstacle_field u_dut_a (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame_a), .start(start_a), .rnd(rnd),
    .obj_draw(obj_draw_a), .plr_draw(plr_draw_a), .obj_x(obj_x_a), .obj_y(obj_y_a),
    .obj_any(obj_any_a), .obj_sel(obj_sel_a), .state(state_a), .dead(dead_a),
    .score(score_a), .level(level_a), .hit_idx(hit_idx_a)
  );

  obstacle_field #(
    .N_OBJ(2), .Y_INIT(230), .Y_STAG(0), .Y_FLOOR(230), .Y_RESPAWN(230)
  ) u_dut_b (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame_b), .start(start_b), .rnd(rnd),
    .obj_draw(obj_draw_b), .plr_draw(plr_draw_b), .obj_x(obj_x_b), .obj_y(obj_y_b),
    .obj_any(obj_any_b), .obj_sel(obj_sel_b), .state(state_b), .dead(dead_b),
    .score(score_b), .level(level_b), .hit_idx(hit_idx_b)
  );

  function automatic logic signed [15:0] ax(input int i);
    return obj_x_a[i*16 +: 16];
  endfunction
  function automatic logic signed [15:0] ay(input int i);
    return obj_y_a[i*16 +: 16];
  endfunction
  function automatic logic signed [15:0] bx(input int i);
    return obj_x_b[i*16 +: 16];
  endfunction
  function automatic logic signed [15:0] by(input int i);
    return obj_y_b[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic frames_a(input int n);
    repeat (n) begin
      frame_a = 1'b1; tick(); frame_a = 1'b0; tick();
    end
  endtask

  task automatic frames_b(input int n);
    repeat (n) begin
      frame_b = 1'b1; tick(); frame_b = 1'b0; tick();
    end
  endtask

  task automatic check_reset_positions(input string tag);
    logic signed [15:0] ex, ey;
    for (int i = 0; i < 5; i++) begin
      ex = 16'(158 + 64 * i);
      ey = 16'(-300 - 50 * i);
      n_chk++;
      if (ax(i) !== ex) begin
        $display("FAIL %s obj_x[%0d] got %0d exp %0d", tag, i, ax(i), ex); n_fail++;
      end
      n_chk++;
      if (ay(i) !== ey) begin
        $display("FAIL %s obj_y[%0d] got %0d exp %0d", tag, i, ay(i), ey); n_fail++;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if (state_a !== 2'd0) begin $display("FAIL rst_state got %0d exp 0", state_a); n_fail++; end
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_positions("reset");
    n_chk++;
    if (dead_a !== 1'b0 || score_a !== 8'd0 || level_a !== 4'd0 || hit_idx_a !== 3'd0) begin
      $display("FAIL reset_flags got dead=%0d score=%0d level=%0d hit=%0d exp 0,0,0,0",
               dead_a, score_a, level_a, hit_idx_a);
      n_fail++;
    end
  endtask

  task automatic test_idle_frames();
    frames_a(3);
    n_chk++;
    if (state_a !== 2'd0) begin $display("FAIL idle_state got %0d exp 0", state_a); n_fail++; end
    check_reset_positions("idle_frames");
  endtask

  task automatic test_motion();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_chk++;
    if (state_a !== 2'd1) begin $display("FAIL start_to_play got %0d exp 1", state_a); n_fail++; end
    frames_a(10);
    n_chk++;
    if (ay(0) !== -16'sd290) begin $display("FAIL motion_y0 got %0d exp -290", ay(0)); n_fail++; end
    n_chk++;
    if (ay(4) !== -16'sd490) begin $display("FAIL motion_y4 got %0d exp -490", ay(4)); n_fail++; end
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_chk++;
    if (state_a !== 2'd1) begin $display("FAIL start_in_play got %0d exp 1", state_a); n_fail++; end
  endtask

  task automatic test_respawn();
    frames_a(521);
    n_chk++;
    if (ay(0) !== 16'sd231) begin $display("FAIL pre_respawn_y0 got %0d exp 231", ay(0)); n_fail++; end
    n_chk++;
    if (score_a !== 8'd0) begin $display("FAIL pre_respawn_score got %0d exp 0", score_a); n_fail++; end
    frames_a(1);
    n_chk++;
    if (ay(0) !== -16'sd300) begin $display("FAIL respawn_y0 got %0d exp -300", ay(0)); n_fail++; end
    n_chk++;
    if (ax(0) !== 16'sd174) begin $display("FAIL respawn_x0 got %0d exp 174", ax(0)); n_fail++; end
    n_chk++;
    if (score_a !== 8'd1) begin $display("FAIL respawn_score got %0d exp 1", score_a); n_fail++; end
    n_chk++;
    if (ay(1) !== 16'sd182 || ax(1) !== 16'sd222) begin
      $display("FAIL respawn_obj1 got x=%0d y=%0d exp x=222 y=182", ax(1), ay(1)); n_fail++;
    end
  endtask

  task automatic test_collision();
    plr_draw_a = 1'b1; obj_draw_a = 5'b00000; tick();
    n_chk++;
    if (state_a !== 2'd1) begin $display("FAIL plr_only_state got %0d exp 1", state_a); n_fail++; end
    plr_draw_a = 1'b0; obj_draw_a = 5'b10100; #1;
    n_chk++;
    if (obj_any_a !== 1'b1 || obj_sel_a !== 3'd2) begin
      $display("FAIL encoder got any=%0d sel=%0d exp any=1 sel=2", obj_any_a, obj_sel_a); n_fail++;
    end
    tick();
    n_chk++;
    if (state_a !== 2'd1) begin $display("FAIL obj_only_state got %0d exp 1", state_a); n_fail++; end
    plr_draw_a = 1'b1; frame_a = 1'b1; tick();
    plr_draw_a = 1'b0; obj_draw_a = '0; frame_a = 1'b0;
    n_chk++;
    if (state_a !== 2'd2 || dead_a !== 1'b1) begin
      $display("FAIL hit_state got state=%0d dead=%0d exp 2,1", state_a, dead_a); n_fail++;
    end
    n_chk++;
    if (hit_idx_a !== 3'd2) begin $display("FAIL hit_idx got %0d exp 2", hit_idx_a); n_fail++; end
    n_chk++;
    if (ay(0) !== -16'sd299 || ay(1) !== 16'sd183) begin
      $display("FAIL hit_frame_motion got y0=%0d y1=%0d exp -299,183", ay(0), ay(1)); n_fail++;
    end
    frames_a(3);
    n_chk++;
    if (ay(0) !== -16'sd299 || ay(1) !== 16'sd183 || score_a !== 8'd1) begin
      $display("FAIL dead_frozen got y0=%0d y1=%0d score=%0d exp -299,183,1", ay(0), ay(1), score_a);
      n_fail++;
    end
  endtask

  task automatic test_restart();
    start_a = 1'b1; tick(); start_a = 1'b0;
    n_chk++;
    if (state_a !== 2'd0 || dead_a !== 1'b0) begin
      $display("FAIL restart_state got state=%0d dead=%0d exp 0,0", state_a, dead_a); n_fail++;
    end
    n_chk++;
    if (score_a !== 8'd0) begin $display("FAIL restart_score got %0d exp 0", score_a); n_fail++; end
    check_reset_positions("restart");
  endtask

  task automatic test_reset_mid_play();
    start_a = 1'b1; tick(); start_a = 1'b0;
    frames_a(5);
    n_chk++;
    if (state_a !== 2'd1 || ay(0) !== -16'sd295) begin
      $display("FAIL replay got state=%0d y0=%0d exp 1,-295", state_a, ay(0)); n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (state_a !== 2'd0 || score_a !== 8'd0 || hit_idx_a !== 3'd0) begin
      $display("FAIL async_rst got state=%0d score=%0d hit=%0d exp 0,0,0", state_a, score_a, hit_idx_a);
      n_fail++;
    end
    check_reset_positions("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back_respawn();
    rnd = 8'hF0;
    start_b = 1'b1; tick(); start_b = 1'b0;
    frames_b(2);
    n_chk++;
    if (score_b !== 8'd2) begin $display("FAIL dual_respawn_score got %0d exp 2", score_b); n_fail++; end
    n_chk++;
    if (bx(0) !== 16'sd398 || bx(1) !== 16'sd206) begin
      $display("FAIL dual_respawn_x got x0=%0d x1=%0d exp 398,206", bx(0), bx(1)); n_fail++;
    end
    n_chk++;
    if (by(0) !== 16'sd230 || by(1) !== 16'sd230) begin
      $display("FAIL dual_respawn_y got y0=%0d y1=%0d exp 230,230", by(0), by(1)); n_fail++;
    end
    frames_b(252);
    n_chk++;
    if (score_b !== 8'd254) begin $display("FAIL score_254 got %0d exp 254", score_b); n_fail++; end
    n_chk++;
    if (level_b !== 4'd15) begin $display("FAIL level_15 got %0d exp 15", level_b); n_fail++; end
    frames_b(2);
    n_chk++;
    if (score_b !== 8'd255) begin $display("FAIL score_sat got %0d exp 255", score_b); n_fail++; end
    frames_b(2);
    n_chk++;
    if (score_b !== 8'd255 || state_b !== 2'd1) begin
      $display("FAIL score_hold got score=%0d state=%0d exp 255,1", score_b, state_b); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_motion();
    test_respawn();
    test_collision();
    test_restart();
    test_reset_mid_play();
    test_back_to_back_respawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
